// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider: default width,
// operating-mode encoding and divisor helper functions.
package clk_div_pkg;

  localparam int CLK_DIV_CNT_WIDTH = 16;

  typedef enum logic [1:0] {
    MODE_STOP = 2'd0,
    MODE_ONE  = 2'd1,
    MODE_NORM = 2'd2
  } div_mode_t;

  // High-phase length; odd divisors give the extra cycle to the low phase.
  function automatic logic [31:0] half_period(input logic [31:0] n);
    return n >> 1;
  endfunction

  function automatic logic is_stop(input logic [31:0] n);
    return (n == 32'd0);
  endfunction

endpackage

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with tick strobe. New divisors
// are staged as pending and only switched in at a period boundary.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int P_CNT_WIDTH = CLK_DIV_CNT_WIDTH,
  parameter int P_DIV_RESET = 10
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_en,
  input  logic [P_CNT_WIDTH-1:0] i_div_val,
  input  logic                   i_div_load,
  output logic                   o_clk_div,
  output logic                   o_tick,
  output logic [P_CNT_WIDTH-1:0] o_div_cur,
  output logic                   o_pend
);

  localparam logic [P_CNT_WIDTH-1:0] C_ONE     = P_CNT_WIDTH'(1);
  localparam logic [P_CNT_WIDTH-1:0] C_DIV_RST = P_CNT_WIDTH'(P_DIV_RESET);

  logic [P_CNT_WIDTH-1:0] r_cnt;
  logic                   r_clk_div;
  logic                   r_tick;
  logic [P_CNT_WIDTH-1:0] r_div_cur;
  logic                   r_pend;
  logic [P_CNT_WIDTH-1:0] r_pend_val;

  logic [P_CNT_WIDTH-1:0] w_cnt_next;
  logic                   w_clk_next;
  logic                   w_tick_next;
  logic [P_CNT_WIDTH-1:0] w_div_next;
  logic                   w_pend_next;
  logic [P_CNT_WIDTH-1:0] w_pend_val_next;

  div_mode_t              w_mode;
  logic [P_CNT_WIDTH-1:0] w_half;
  logic                   w_last;
  logic                   w_fall;
  logic                   w_apply;

  assign w_mode = is_stop(32'(r_div_cur)) ? MODE_STOP :
                  (r_div_cur == C_ONE)    ? MODE_ONE  : MODE_NORM;
  assign w_half = P_CNT_WIDTH'(half_period(32'(r_div_cur)));

  // Both subtractions are only meaningful in MODE_NORM, where N>=2 and H>=1.
  assign w_last = (r_cnt == (r_div_cur - C_ONE));
  assign w_fall = (r_cnt == (w_half - C_ONE));

  // Only a value registered on an earlier cycle may be applied.
  assign w_apply = i_en && r_pend && ((w_mode != MODE_NORM) || w_last);

  always_comb begin
    w_cnt_next      = r_cnt;
    w_clk_next      = r_clk_div;
    w_tick_next     = 1'b0;
    w_div_next      = r_div_cur;
    w_pend_next     = r_pend;
    w_pend_val_next = r_pend_val;

    if (i_div_load) begin
      w_pend_val_next = i_div_val;
      w_pend_next     = 1'b1;
    end

    if (w_apply) begin
      w_div_next = r_pend_val;
      w_cnt_next = '0;
      if (!i_div_load) begin
        w_pend_next = 1'b0;
      end
      if (w_mode == MODE_NORM) begin
        w_clk_next  = 1'b1;
        w_tick_next = 1'b1;
      end else begin
        w_clk_next  = (r_pend_val == C_ONE);
      end
    end else if (i_en) begin
      case (w_mode)
        MODE_STOP: begin
          w_cnt_next = '0;
          w_clk_next = 1'b0;
        end
        MODE_ONE: begin
          w_cnt_next  = '0;
          w_clk_next  = 1'b1;
          w_tick_next = 1'b1;
        end
        default: begin
          if (w_last) begin
            w_cnt_next  = '0;
            w_clk_next  = 1'b1;
            w_tick_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + C_ONE;
            if (w_fall) begin
              w_clk_next = 1'b0;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt      <= '0;
      r_clk_div  <= 1'b0;
      r_tick     <= 1'b0;
      r_div_cur  <= C_DIV_RST;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
    end else begin
      r_cnt      <= w_cnt_next;
      r_clk_div  <= w_clk_next;
      r_tick     <= w_tick_next;
      r_div_cur  <= w_div_next;
      r_pend     <= w_pend_next;
      r_pend_val <= w_pend_val_next;
    end
  end

  assign o_clk_div = r_clk_div;
  assign o_tick    = r_tick;
  assign o_div_cur = r_div_cur;
  assign o_pend    = r_pend;

endmodule
